// File: rtl/result_writeback_buffer.sv
// Result writeback buffer: buffers N-wide result vectors in a small FIFO and streams
// them to memory as P-element beats at consecutive element addresses.
module result_writeback_buffer #(
    parameter int DATA_WIDTH                   = 32,
    parameter int N                            = 4,
    parameter int PARALLEL_DATA_STREAMING_SIZE = 4,
    parameter int MEMORY_ADDRESS_BITS          = 64,
    parameter int MAX_MATRIX_LENGTH            = 4096,
    parameter int COUNTER_BITS                 = $clog2(MAX_MATRIX_LENGTH + 1),
    parameter int FIFO_DEPTH                   = 4
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic                                                      instruction_valid,
    output logic                                                      instruction_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0]                            address_input,
    input  logic [COUNTER_BITS-1:0]                                   length_input,
    input  logic                                                      processor_output_valid,
    output logic                                                      processor_output_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]                              processor_output_data,
    input  logic                                                      processor_output_last,
    output logic                                                      memory_write_valid,
    input  logic                                                      memory_write_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0]                            memory_address,
    output logic [PARALLEL_DATA_STREAMING_SIZE-1:0][DATA_WIDTH-1:0]   memory_data,
    output logic                                                      done,
    output logic                                                      protocol_error
);
    localparam int P          = PARALLEL_DATA_STREAMING_SIZE;
    localparam int CHUNKS     = N / P;
    localparam int CHUNK_BITS = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int BEAT_BITS  = COUNTER_BITS + CHUNK_BITS;
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                     state_q, state_d;
    logic [COUNTER_BITS-1:0]        recv_cnt_q, recv_cnt_d;
    logic [COUNTER_BITS-1:0]        length_q;
    logic [BEAT_BITS-1:0]           beat_cnt_q, beat_cnt_d;
    logic [BEAT_BITS-1:0]           total_beats;
    logic [CHUNK_BITS-1:0]          chunk_q, chunk_d;
    logic [PTR_BITS:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                           perr_q, perr_d;
    logic                           done_q, done_d;
    logic [MEMORY_ADDRESS_BITS-1:0] base_q;
    logic [N-1:0][DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
    logic [N*DATA_WIDTH-1:0]        head;

    logic run, fifo_empty, fifo_full;
    logic instr_hs, push, beat_hs, last_chunk, last_beat;

    assign run        = (state_q == S_RUN);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
                        (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);

    assign instruction_ready      = !run;
    assign processor_output_ready = run && !fifo_full && (recv_cnt_q < length_q);
    assign memory_write_valid     = !fifo_empty;
    assign done                   = done_q;
    assign protocol_error         = perr_q;

    assign instr_hs    = instruction_valid && instruction_ready;
    assign push        = processor_output_valid && processor_output_ready;
    assign beat_hs     = memory_write_valid && memory_write_ready;
    assign last_chunk  = (chunk_q == CHUNK_BITS'(CHUNKS - 1));
    assign total_beats = BEAT_BITS'(length_q) * BEAT_BITS'(CHUNKS);
    assign last_beat   = beat_hs && (beat_cnt_q == total_beats - BEAT_BITS'(1));

    // Beat payload and address come straight from the FIFO head and registered counters.
    assign head           = fifo_q[rd_ptr_q[PTR_BITS-1:0]];
    assign memory_data    = (P*DATA_WIDTH)'(head >> (int'(chunk_q) * P * DATA_WIDTH));
    assign memory_address = base_q + MEMORY_ADDRESS_BITS'(beat_cnt_q) * MEMORY_ADDRESS_BITS'(P);

    always_comb begin
        state_d    = state_q;
        recv_cnt_d = recv_cnt_q;
        beat_cnt_d = beat_cnt_q;
        chunk_d    = chunk_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        perr_d     = perr_q;
        done_d     = 1'b0;

        if (instr_hs) begin
            state_d    = S_RUN;
            recv_cnt_d = '0;
            beat_cnt_d = '0;
            perr_d     = 1'b0;
        end

        if (push) begin
            wr_ptr_d   = wr_ptr_q + (PTR_BITS+1)'(1);
            recv_cnt_d = recv_cnt_q + COUNTER_BITS'(1);
            if (processor_output_last != (recv_cnt_q == length_q - COUNTER_BITS'(1)))
                perr_d = 1'b1;
        end

        if (beat_hs) begin
            beat_cnt_d = beat_cnt_q + BEAT_BITS'(1);
            if (last_chunk) begin
                chunk_d  = '0;
                rd_ptr_d = rd_ptr_q + (PTR_BITS+1)'(1);
            end else begin
                chunk_d = chunk_q + CHUNK_BITS'(1);
            end
        end

        // A zero-length tile completes on its first RUN cycle.
        if (run && ((total_beats == '0) || last_beat)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            recv_cnt_q <= '0;
            beat_cnt_q <= '0;
            chunk_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            perr_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            recv_cnt_q <= recv_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            chunk_q    <= chunk_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            perr_q     <= perr_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (instr_hs) begin
            base_q   <= address_input;
            length_q <= length_input;
        end
        if (push)
            fifo_q[wr_ptr_q[PTR_BITS-1:0]] <= processor_output_data;
    end

endmodule

// File: tb/tb_result_writeback_buffer.sv
// Directed bench for result_writeback_buffer: one instance with P=N=4 and one with P=2.
module tb_result_writeback_buffer;
    localparam int DW   = 32;
    localparam int N    = 4;
    localparam int MAB  = 64;
    localparam int MAXL = 4096;
    localparam int CB   = $clog2(MAXL + 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic                 a_iv, a_ir, a_pv, a_pr, a_pl, a_mv, a_mr, a_done, a_perr;
    logic [MAB-1:0]       a_ia, a_ma;
    logic [CB-1:0]        a_il;
    logic [N-1:0][DW-1:0] a_pd;
    logic [3:0][DW-1:0]   a_md;

    logic                 b_iv, b_ir, b_pv, b_pr, b_pl, b_mv, b_mr, b_done, b_perr;
    logic [MAB-1:0]       b_ia, b_ma;
    logic [CB-1:0]        b_il;
    logic [N-1:0][DW-1:0] b_pd;
    logic [1:0][DW-1:0]   b_md;

    result_writeback_buffer #(
        .DATA_WIDTH(DW), .N(N), .PARALLEL_DATA_STREAMING_SIZE(4), .MEMORY_ADDRESS_BITS(MAB),
        .MAX_MATRIX_LENGTH(MAXL), .COUNTER_BITS(CB), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset(reset),
        .instruction_valid(a_iv), .instruction_ready(a_ir),
        .address_input(a_ia), .length_input(a_il),
        .processor_output_valid(a_pv), .processor_output_ready(a_pr),
        .processor_output_data(a_pd), .processor_output_last(a_pl),
        .memory_write_valid(a_mv), .memory_write_ready(a_mr),
        .memory_address(a_ma), .memory_data(a_md),
        .done(a_done), .protocol_error(a_perr)
    );

    result_writeback_buffer #(
        .DATA_WIDTH(DW), .N(N), .PARALLEL_DATA_STREAMING_SIZE(2), .MEMORY_ADDRESS_BITS(MAB),
        .MAX_MATRIX_LENGTH(MAXL), .COUNTER_BITS(CB), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(reset),
        .instruction_valid(b_iv), .instruction_ready(b_ir),
        .address_input(b_ia), .length_input(b_il),
        .processor_output_valid(b_pv), .processor_output_ready(b_pr),
        .processor_output_data(b_pd), .processor_output_last(b_pl),
        .memory_write_valid(b_mv), .memory_write_ready(b_mr),
        .memory_address(b_ma), .memory_data(b_md),
        .done(b_done), .protocol_error(b_perr)
    );

    // Beat capture: sampled mid-cycle, the handshake completes on the next rising edge.
    logic [MAB-1:0] a_qa[$], b_qa[$];
    logic [127:0]   a_qd[$], b_qd[$];
    int a_done_cnt = 0, b_done_cnt = 0;
    int a_beat_cyc = 0, a_done_cyc = 0;

    always @(negedge clk) begin
        if (a_mv && a_mr) begin
            a_qa.push_back(a_ma);
            a_qd.push_back(a_md);
            a_beat_cyc = cyc;
        end
        if (a_done) begin
            a_done_cnt++;
            a_done_cyc = cyc;
        end
        if (b_mv && b_mr) begin
            b_qa.push_back(b_ma);
            b_qd.push_back({64'b0, b_md});
        end
        if (b_done) b_done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] vec(input int b);
        vec = {32'(b + 3), 32'(b + 2), 32'(b + 1), 32'(b)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_instr(input logic [MAB-1:0] addr, input int len);
        a_ia = addr; a_il = CB'(len); a_iv = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_ir) begin tick(); a_iv = 1'b0; return; end
        end
        a_iv = 1'b0;
        checki("a_instr_timeout", 0, 1);
    endtask

    task automatic b_instr(input logic [MAB-1:0] addr, input int len);
        b_ia = addr; b_il = CB'(len); b_iv = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_ir) begin tick(); b_iv = 1'b0; return; end
        end
        b_iv = 1'b0;
        checki("b_instr_timeout", 0, 1);
    endtask

    task automatic a_push(input logic [127:0] v, input logic last);
        a_pd = v; a_pl = last; a_pv = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_pr) begin tick(); a_pv = 1'b0; return; end
        end
        a_pv = 1'b0;
        checki("a_push_timeout", 0, 1);
    endtask

    task automatic b_push(input logic [127:0] v, input logic last);
        b_pd = v; b_pl = last; b_pv = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_pr) begin tick(); b_pv = 1'b0; return; end
        end
        b_pv = 1'b0;
        checki("b_push_timeout", 0, 1);
    endtask

    task automatic wait_a_done(input string tag, input int target);
        for (int i = 0; i < 60; i++) begin
            if (a_done_cnt >= target) break;
            tick();
        end
        repeat (3) tick();
        checki(tag, a_done_cnt, target);
    endtask

    initial begin
        logic [127:0] v;
        int acc, hs, d0;
        logic prev_stall;
        logic [MAB-1:0] prev_a;
        logic [127:0] prev_d;

        a_iv = 0; a_ia = '0; a_il = '0; a_pv = 0; a_pd = '0; a_pl = 0; a_mr = 1;
        b_iv = 0; b_ia = '0; b_il = '0; b_pv = 0; b_pd = '0; b_pl = 0; b_mr = 0;

        // Reset values, in reset and on the cycle after
        repeat (2) tick();
        checki("rst_ir", int'(a_ir), 1);
        checki("rst_pr", int'(a_pr), 0);
        checki("rst_mv", int'(a_mv), 0);
        checki("rst_done", int'(a_done), 0);
        checki("rst_perr", int'(a_perr), 0);
        reset = 1'b0;
        tick();
        checki("post_rst_ir", int'(a_ir), 1);
        checki("post_rst_pr", int'(a_pr), 0);
        checki("post_rst_mv", int'(a_mv), 0);
        checki("post_rst_done", int'(a_done), 0);
        checki("post_rst_b_ir", int'(b_ir), 1);

        // Basic tile, P=N=4
        a_instr(64'h100, 3);
        a_push(vec(1), 1'b0);
        a_push(vec(5), 1'b0);
        a_push(vec(9), 1'b1);
        wait_a_done("t1_done_cnt", 1);
        checki("t1_beats", a_qa.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_addr%0d", i), 128'(a_qa[i]), 128'(64'h100 + 64'(4 * i)));
            check($sformatf("t1_data%0d", i), a_qd[i], vec(1 + 4 * i));
        end
        checki("t1_done_after_beat", a_done_cyc, a_beat_cyc + 1);
        checki("t1_perr", int'(a_perr), 0);
        checki("t1_idle", int'(a_ir), 1);

        // P=2 with memory ready toggling; payload must hold while stalled
        b_instr(64'h2000, 2);
        b_push(vec(32'h10), 1'b0);
        b_push(vec(32'h20), 1'b1);
        prev_stall = 1'b0; prev_a = '0; prev_d = '0;
        for (int i = 0; i < 16; i++) begin
            b_mr = (i % 2 == 0);
            @(negedge clk);
            if (prev_stall && b_mv) begin
                check($sformatf("t2_hold_addr%0d", i), 128'(b_ma), 128'(prev_a));
                check($sformatf("t2_hold_data%0d", i), 128'(b_md), prev_d);
            end
            prev_stall = b_mv && !b_mr;
            prev_a = b_ma;
            prev_d = 128'(b_md);
            tick();
        end
        checki("t2_done_cnt", b_done_cnt, 1);
        checki("t2_beats", b_qa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            v = vec((i < 2) ? 32'h10 : 32'h20);
            check($sformatf("t2_addr%0d", i), 128'(b_qa[i]), 128'(64'h2000 + 64'(2 * i)));
            check($sformatf("t2_data%0d", i), b_qd[i], (i % 2 == 0) ? {64'b0, v[63:0]} : {64'b0, v[127:64]});
        end
        checki("t2_perr", int'(b_perr), 0);

        // FIFO fill under memory back-pressure, processor always valid
        a_qa.delete(); a_qd.delete();
        a_mr = 1'b0;
        a_instr(64'h400, 8);
        acc = 0;
        a_pd = vec(100); a_pl = 1'b0; a_pv = 1'b1;
        for (int i = 0; i < 80 && acc < 8; i++) begin
            if (i == 10) begin
                checki("t3_accepted_while_stalled", acc, 4);
                checki("t3_ready_when_full", int'(a_pr), 0);
                a_mr = 1'b1;
            end
            @(negedge clk);
            if (a_pr) acc++;
            tick();
            a_pd = vec(100 + 4 * acc);
            a_pl = (acc == 7);
        end
        a_pv = 1'b0;
        checki("t3_accepted_total", acc, 8);
        wait_a_done("t3_done_cnt", 2);
        checki("t3_beats", a_qa.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_addr%0d", i), 128'(a_qa[i]), 128'(64'h400 + 64'(4 * i)));
            check($sformatf("t3_data%0d", i), a_qd[i], vec(100 + 4 * i));
        end
        checki("t3_perr", int'(a_perr), 0);

        // Misplaced last marker: flag is sticky, data still written
        a_qa.delete(); a_qd.delete();
        a_instr(64'h800, 2);
        checki("t4_perr_before", int'(a_perr), 0);
        a_push(vec(20), 1'b1);
        checki("t4_perr_set", int'(a_perr), 1);
        a_push(vec(24), 1'b1);
        wait_a_done("t4_done_cnt", 3);
        checki("t4_beats", a_qa.size(), 2);
        check("t4_addr1", 128'(a_qa[1]), 128'(64'h804));
        check("t4_data1", a_qd[1], vec(24));
        checki("t4_perr_sticky", int'(a_perr), 1);
        a_instr(64'h900, 1);
        checki("t4_perr_cleared", int'(a_perr), 0);
        a_push(vec(30), 1'b1);
        wait_a_done("t4b_done_cnt", 4);
        check("t4b_addr", 128'(a_qa[2]), 128'(64'h900));
        checki("t4b_perr", int'(a_perr), 0);

        // Zero-length tile
        a_qa.delete(); a_qd.delete();
        a_instr(64'hA00, 0);
        hs = cyc;
        wait_a_done("t5_done_cnt", 5);
        checki("t5_beats", a_qa.size(), 0);
        checki("t5_done_latency", int'((a_done_cyc - hs) <= 1), 1);
        checki("t5_idle", int'(a_ir), 1);

        // Reset mid-tile discards the pending beat
        a_mr = 1'b0;
        a_instr(64'hC00, 3);
        a_push(vec(40), 1'b0);
        checki("t6_pending", int'(a_mv), 1);
        reset = 1'b1;
        tick();
        checki("t6_rst_mv", int'(a_mv), 0);
        checki("t6_rst_ir", int'(a_ir), 1);
        reset = 1'b0;
        a_mr = 1'b1;
        tick();
        checki("t6_post_mv", int'(a_mv), 0);
        checki("t6_post_ir", int'(a_ir), 1);
        checki("t6_post_pr", int'(a_pr), 0);
        repeat (3) tick();
        checki("t6_no_writes", a_qa.size(), 0);
        d0 = a_done_cnt;
        a_instr(64'hD00, 1);
        a_push(vec(50), 1'b1);
        wait_a_done("t6_done_cnt", d0 + 1);
        checki("t6_beats", a_qa.size(), 1);
        check("t6_addr", 128'(a_qa[0]), 128'(64'hD00));
        check("t6_data", a_qd[0], vec(50));
        checki("t6_perr", int'(a_perr), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/result_writeback_buffer.md
Name: result_writeback_buffer

Overview:
- Output-side counterpart of the operand memory buffer: accepts N-wide result vectors from the processor array over a valid/ready stream with a "last" marker and writes them back to memory.
- Writes PARALLEL_DATA_STREAMING_SIZE values per memory beat at consecutive element addresses.
- The controller issues one instruction per result tile (base address, number of vectors). A small vector FIFO decouples processor output from memory back-pressure.

Parameters:
- DATA_WIDTH, 32: width of one result element (accumulator width).
- N, 4: elements per processor output vector.
- PARALLEL_DATA_STREAMING_SIZE, 4: elements per memory write beat. Must divide N.
- MEMORY_ADDRESS_BITS, 64: memory address width.
- MAX_MATRIX_LENGTH, 4096: maximum vectors per instruction.
- COUNTER_BITS, $clog2(MAX_MATRIX_LENGTH+1): vector counter width.
- FIFO_DEPTH, 4: vector FIFO entries. Power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- instruction_valid  in  1  controller instruction valid.
- instruction_ready  out  1  block idle; can accept an instruction.
- address_input  in  MEMORY_ADDRESS_BITS  base element address of the tile.
- length_input  in  COUNTER_BITS  number of N-vectors to collect.
- processor_output_valid  in  1  processor result vector valid.
- processor_output_ready  out  1  block accepts the vector.
- processor_output_data  in  DATA_WIDTH x [N-1:0]  result vector; element 0 goes to the lowest address.
- processor_output_last  in  1  marks the final vector of the tile.
- memory_write_valid  out  1  write beat valid.
- memory_write_ready  in  1  memory accepts the beat.
- memory_address  out  MEMORY_ADDRESS_BITS  element address of memory_data[0].
- memory_data  out  DATA_WIDTH x [PARALLEL_DATA_STREAMING_SIZE-1:0]  write beat payload.
- done  out  1  one-cycle pulse: tile fully written.
- protocol_error  out  1  sticky "last" mismatch flag.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. All state is cleared to IDLE. FIFO becomes empty, counters 0. Outputs in reset and the cycle after: instruction_ready=1, processor_output_ready=0, memory_write_valid=0, done=0, protocol_error=0. memory_address/memory_data are don't-care while memory_write_valid=0.
- Reset mid-tile: all buffered data is discarded; no further writes are issued.
- States: IDLE, RUN.
  - IDLE: instruction_ready=1. On an instruction handshake, register address and length, clear recv_cnt/beat_cnt/protocol_error, and go to RUN.
  - length_input=0: go to RUN; the completion condition holds at once, so done pulses on the next cycle.
  - RUN: instruction_ready=0.
- Input side:
  - processor_output_ready = RUN && FIFO not full && recv_cnt < length.
  - No same-cycle push/pop bypass when full.
  - On handshake: push the vector, recv_cnt+1.
  - If processor_output_last != (recv_cnt == length-1), set protocol_error. It stays set until the next instruction is accepted. The vector is still accepted and processed normally.
- Output side:
  - memory_write_valid = FIFO not empty.
  - memory_data = chunk c of the head vector, elements [c*P+P-1 : c*P], where P = PARALLEL_DATA_STREAMING_SIZE and c = chunk index 0..N/P-1.
  - memory_address = base + beat_cnt*P (element addressing, wraps modulo 2^MEMORY_ADDRESS_BITS).
  - On each beat handshake: beat_cnt+1, chunk advances. After the last chunk the head is popped and chunk returns to 0.
  - Outputs are driven from registers/FIFO head only. They hold stable while valid && !ready.
- Latency: a vector accepted at edge t gives memory_write_valid=1 in cycle t+1 at the earliest.
- Throughput: one beat per cycle under no back-pressure; with P=N, one vector per cycle sustained.
- Completion: on the handshake of beat number length*N/P (the final beat), go to IDLE. done=1 for exactly the following cycle, in which instruction_ready is also 1.
- Simultaneous push and pop in one cycle: both take effect; occupancy is unchanged.

Test Plan:
- N=4, P=4: instruction addr=0x100, len=3; three vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, last on the third -> beats at 0x100, 0x104, 0x108 with matching data. done pulses once, 1 cycle after the final beat. protocol_error=0.
- N=4, P=2, len=2, memory_write_ready toggling 1/0 -> 4 beats at base+0/2/4/6 carrying {e0,e1},{e2,e3},... Data/address stable during stalls.
- FIFO_DEPTH=4, memory_write_ready=0 for 10 cycles, processor always valid, len=8 -> exactly 4 vectors accepted, then processor_output_ready=0. After release all 8 are written in order; no loss or duplication.
- len=2 with last on vector 0 -> protocol_error=1 after that edge; both vectors are still written. The flag clears when the next instruction is accepted.
- len=0 -> no memory beats; done pulses 1 cycle after the instruction handshake.
- Reset asserted after 1 of 3 vectors (one beat pending) -> next cycle memory_write_valid=0, instruction_ready=1. A new len=1 instruction then completes normally at its own base address.
